// File: rtl/instr_exec_unit.sv
// instr_exec_unit: walks instruction register entries, executes each opcode, presents results on a valid/ready port
module instr_exec_unit #(
  parameter int OPERAND_W = 32,
  parameter int ADDR_W = 5,
  parameter int RESULT_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_ptr,
  input  logic [ADDR_W:0]      count,
  output logic [ADDR_W-1:0]    read_pointer,
  input  logic [2:0]           instr_opcode,
  input  logic [OPERAND_W-1:0] instr_operand_a,
  input  logic [OPERAND_W-1:0] instr_operand_b,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [RESULT_W-1:0]  res_data,
  output logic [ADDR_W-1:0]    res_addr,
  output logic                 res_err,
  output logic                 done
);
  localparam int CW = $clog2(OPERAND_W) + 1;
  localparam int XW = RESULT_W - OPERAND_W;
  localparam logic [CW-1:0] CNT_END = CW'(OPERAND_W);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, DIVIDE, OUTPUT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0] left_q, left_d;
  logic [2:0] op_q, op_d;
  logic signed [OPERAND_W-1:0] a_q, a_d, b_q, b_d;
  logic [RESULT_W-1:0] data_q, data_d;
  logic err_q, err_d, done_q, done_d;
  logic [OPERAND_W-1:0] quo_q, quo_d, rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [RESULT_W-1:0] ax, bx;
  logic [OPERAND_W-1:0] ua, ub;
  logic [OPERAND_W:0] sh, diff;
  logic [RESULT_W-1:0] qz, rz;
  logic is_div, b_zero, last;
  assign ax = {{XW{a_q[OPERAND_W-1]}}, a_q};
  assign bx = {{XW{b_q[OPERAND_W-1]}}, b_q};
  assign ua = a_q[OPERAND_W-1] ? OPERAND_W'(-a_q) : a_q;
  assign ub = b_q[OPERAND_W-1] ? OPERAND_W'(-b_q) : b_q;
  assign sh = {rem_q, quo_q[OPERAND_W-1]};
  assign diff = sh - {1'b0, ub};
  assign qz = {{XW{1'b0}}, quo_q};
  assign rz = {{XW{1'b0}}, rem_q};
  assign is_div = op_q[2] & op_q[1];
  assign b_zero = ~|b_q;
  assign last = left_q == (ADDR_W+1)'(1);
  assign read_pointer = ptr_q;
  assign res_addr = ptr_q;
  assign res_data = data_q;
  assign res_err = err_q;
  assign done = done_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      left_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      left_q <= left_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      data_q <= data_d;
      err_q <= err_d;
      done_q <= done_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (start && |count) ? FETCH : IDLE;
      FETCH:   state_d = EXEC;
      EXEC:    state_d = (is_div && !b_zero) ? DIVIDE : OUTPUT;
      DIVIDE:  state_d = (cnt_q == CNT_END) ? OUTPUT : DIVIDE;
      OUTPUT:  state_d = res_ready ? (last ? IDLE : FETCH) : OUTPUT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy = state_q != IDLE;
    res_valid = state_q == OUTPUT;
  end
  always_comb begin
    ptr_d = ptr_q;
    left_d = left_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    data_d = data_q;
    err_d = err_q;
    done_d = 1'b0;
    quo_d = quo_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        ptr_d = (start && |count) ? start_ptr : ptr_q;
        left_d = (start && |count) ? count : left_q;
      end
      FETCH: begin
        op_d = instr_opcode;
        a_d = instr_operand_a;
        b_d = instr_operand_b;
      end
      EXEC: begin
        err_d = is_div & b_zero;
        quo_d = ua;
        rem_d = '0;
        cnt_d = '0;
        case (op_q)
          3'd1:    data_d = ax;
          3'd2:    data_d = bx;
          3'd3:    data_d = ax + bx;
          3'd4:    data_d = ax - bx;
          3'd5:    data_d = ax * bx;
          default: data_d = '0;
        endcase
      end
      DIVIDE: begin
        cnt_d = cnt_q + CW'(1);
        quo_d = {quo_q[OPERAND_W-2:0], ~diff[OPERAND_W]};
        rem_d = diff[OPERAND_W] ? sh[OPERAND_W-1:0] : diff[OPERAND_W-1:0];
        if (cnt_q == CNT_END)
          data_d = op_q[0] ? (a_q[OPERAND_W-1] ? -rz : rz)
                           : ((a_q[OPERAND_W-1] ^ b_q[OPERAND_W-1]) ? -qz : qz);
      end
      OUTPUT: begin
        left_d = res_ready ? left_q - (ADDR_W+1)'(1) : left_q;
        done_d = res_ready & last;
        ptr_d = (res_ready && !last) ? ptr_q + ADDR_W'(1) : ptr_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_instr_exec_unit.sv
// tb_instr_exec_unit: randomized and directed checks of instr_exec_unit against an arithmetic reference model
module tb_instr_exec_unit;
  logic clk = 1'b0;
  logic reset, start, res_ready;
  logic [4:0] start_ptr;
  logic [5:0] count;
  logic [4:0] read_pointer, res_addr;
  logic [2:0] instr_opcode;
  logic [31:0] instr_operand_a, instr_operand_b;
  logic busy, res_valid, res_err, done;
  logic [63:0] res_data;
  int mem_op[32];
  int mem_a[32];
  int mem_b[32];
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  assign instr_opcode = 3'(mem_op[read_pointer]);
  assign instr_operand_a = mem_a[read_pointer];
  assign instr_operand_b = mem_b[read_pointer];
  instr_exec_unit dut (
    .clk(clk), .reset(reset), .start(start), .start_ptr(start_ptr), .count(count),
    .read_pointer(read_pointer), .instr_opcode(instr_opcode),
    .instr_operand_a(instr_operand_a), .instr_operand_b(instr_operand_b),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_addr(res_addr), .res_err(res_err), .done(done)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask
  task automatic put(input int i, input int op, input int a, input int b);
    mem_op[i] = op;
    mem_a[i] = a;
    mem_b[i] = b;
  endtask
  function automatic longint ref_res(input int i);
    longint la = mem_a[i];
    longint lb = mem_b[i];
    case (mem_op[i])
      1: return la;
      2: return lb;
      3: return la + lb;
      4: return la - lb;
      5: return la * lb;
      6: return (lb == 0) ? 0 : la / lb;
      7: return (lb == 0) ? 0 : la % lb;
      default: return 0;
    endcase
  endfunction
  function automatic bit ref_err(input int i);
    return mem_op[i] >= 6 && mem_b[i] == 0;
  endfunction
  function automatic int exp_lat(input int i);
    return (mem_op[i] >= 6 && mem_b[i] != 0) ? 36 : 3;
  endfunction
  task automatic run(input int sp, input int cnt, input int stall_k, input int stall_n);
    int lat;
    int addr;
    start_ptr = 5'(sp);
    count = 6'(cnt);
    start = 1'b1;
    res_ready = 1'b1;
    step;
    start = 1'b0;
    lat = 1;
    for (int k = 0; k < cnt; k++) begin
      addr = (sp + k) % 32;
      while (!res_valid && lat < 100) begin
        step;
        lat++;
      end
      chk("valid", res_valid, 1);
      chk("latency", lat, exp_lat(addr));
      chk("data", res_data, ref_res(addr));
      chk("addr", res_addr, addr);
      chk("err", res_err, ref_err(addr));
      chk("busy_run", busy, 1);
      chk("done_early", done, 0);
      if (k == stall_k) begin
        res_ready = 1'b0;
        start = 1'b1;
        start_ptr = 5'd3;
        count = 6'd2;
        repeat (stall_n) begin
          step;
          chk("stall_valid", res_valid, 1);
          chk("stall_data", res_data, ref_res(addr));
          chk("stall_addr", res_addr, addr);
        end
        start = 1'b0;
        res_ready = 1'b1;
      end
      step;
      lat = 1;
    end
    chk("done_pulse", done, 1);
    chk("idle_busy", busy, 0);
    step;
    chk("done_clear", done, 0);
    chk("idle_valid", res_valid, 0);
    chk("idle_stays", busy, 0);
  endtask
  initial begin
    int r;
    for (int i = 0; i < 32; i++) put(i, 0, 0, 0);
    reset = 1'b1;
    start = 1'b0;
    res_ready = 1'b1;
    start_ptr = '0;
    count = '0;
    repeat (2) step;
    chk("rst_ptr", read_pointer, 0);
    chk("rst_data", res_data, 0);
    chk("rst_addr", res_addr, 0);
    chk("rst_err", res_err, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    repeat (3) step;
    chk("quiet_busy", busy, 0);
    chk("quiet_valid", res_valid, 0);
    chk("quiet_ptr", read_pointer, 0);
    put(0, 3, 5, 7);
    put(1, 4, 3, 10);
    put(2, 5, -4, 6);
    put(3, 2, 0, -9);
    run(0, 4, -1, 0);
    put(6, 6, -17, 5);
    put(7, 7, -17, 5);
    run(6, 2, -1, 0);
    put(8, 6, 100, 0);
    put(9, 7, 32'h8000_0000, -1);
    put(10, 6, 32'h8000_0000, -1);
    run(8, 3, -1, 0);
    put(30, 5, -123456, 789);
    put(31, 4, 32'h8000_0000, 1);
    put(0, 1, -1, 5);
    put(1, 0, 44, 55);
    run(30, 4, 1, 5);
    start = 1'b1;
    count = 6'd0;
    start_ptr = 5'd4;
    step;
    start = 1'b0;
    chk("cnt0_busy", busy, 0);
    step;
    chk("cnt0_done", done, 0);
    put(12, 6, 1000003, 7);
    start_ptr = 5'd12;
    count = 6'd1;
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (10) step;
    chk("pre_abort_busy", busy, 1);
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", res_valid, 0);
    chk("abort_ptr", read_pointer, 0);
    run(12, 1, -1, 0);
    repeat (6) begin
      for (int i = 0; i < 32; i++) begin
        r = int'($urandom_range(0, 9));
        put(i, int'($urandom_range(0, 7)), int'($urandom), int'($urandom));
        if (r == 0) mem_b[i] = 0;
        if (r == 1) mem_b[i] = -1;
        if (r == 2) mem_a[i] = 32'h8000_0000;
        if (r == 3) begin
          mem_a[i] = int'($urandom_range(0, 200)) - 100;
          mem_b[i] = int'($urandom_range(0, 26)) - 13;
        end
      end
      run(int'($urandom_range(0, 31)), int'($urandom_range(1, 6)),
          int'($urandom_range(0, 5)), int'($urandom_range(1, 4)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
